dm_cache_controller: RTL and testbench
======================================

// Module: dm_cache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate cache controller between a CPU and a
//  block-wide memory. 1024 lines of 128-bit blocks; CPU reads return one 32-bit word,
//  CPU writes replace the whole 128-bit block. Misses use a valid/ready memory handshake.
// PARAMETERS
//  ADDR_W    32   byte address width
//  BLOCK_W   128  cache block / memory transfer width
//  WORD_W    32   CPU read-data width
//  INDEX_W   10   line index bits (1024 lines); OFFSET_W=4, TAG_W=ADDR_W-INDEX_W-4=18
// PORTS
//  clk              in   1    clock, all logic on rising edge
//  rst              in   1    synchronous, active-high reset
//  cpu_req_addr     in   32   byte address: tag[31:14], index[13:4], offset[3:0]
//  cpu_req_datain   in   128  write block
//  cpu_req_dataout  out  32   read word, block word selected by addr[3:2]
//  cpu_req_rw       in   1    1=write, 0=read
//  cpu_req_valid    in   1    request strobe, sampled only while cache_ready=1
//  cache_ready      out  1    1=idle/accepting; rises when a request completes
//  mem_req_addr     out  32   block address, low 4 bits always 0
//  mem_req_datain   in   128  fill data from memory
//  mem_req_dataout  out  128  write-back data to memory
//  mem_req_rw       out  1    1=write-back, 0=fill read
//  mem_req_valid    out  1    memory request pending
//  mem_req_ready    in   1    memory accepts/completes the request this cycle
// BEHAVIOUR
//  - Reset: all valid and dirty bits cleared; FSM=IDLE; cache_ready=1; mem_req_valid=0;
//    mem_req_rw=0; mem_req_addr=0; mem_req_dataout=0; cpu_req_dataout=0.
//  - FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
//  - IDLE: cache_ready=1. On cpu_req_valid, register addr/rw/datain, drop cache_ready,
//    go COMPARE. A one-cycle valid pulse suffices.
//  - COMPARE: hit = valid[idx] && tag[idx]==req_tag.
//    Read hit: cpu_req_dataout <= block word addr[3:2]; go IDLE (ready back 2 cycles
//    after accept). Write hit: block<=datain, dirty=1; go IDLE.
//    Miss, victim clean or invalid: read -> ALLOCATE; write -> install block
//    (valid=1, dirty=1, tag=req_tag), go IDLE. No fill on a write miss.
//    Miss, victim valid+dirty: go WRITE_BACK.
//  - WRITE_BACK: mem_req_valid=1, rw=1, addr={victim_tag,idx,4'h0}, dataout=victim block.
//    Hold until a cycle with mem_req_ready=1, then clear dirty and go ALLOCATE
//    (read) or install the write block and go IDLE (write).
//  - ALLOCATE: mem_req_valid=1, rw=0, addr={req_tag,idx,4'h0}. On mem_req_ready=1:
//    capture mem_req_datain into line, valid=1, dirty=0, tag=req_tag, go COMPARE
//    (which then hits).
//  - mem_req_valid drops the cycle after the completing ready; addr/rw/dataout stable
//    while valid. mem_req_ready high before valid rises is allowed (1-cycle complete).
//  - cpu_req_valid while cache_ready=0 is ignored (no queueing).
//  - cpu_req_dataout holds its last value until the next read completes.
//  - rst asserted mid-miss: immediate return to IDLE, valid bits cleared, no write-back.
// STRUCTURE
//  - Shared package: state enum, field-width constants, address slicing functions.
//  - One natural sub-module: dm_cache_array (data+tag+valid+dirty storage with one
//    read port and one write port, synchronous clear on rst); FSM in top.
// TESTING
//  - Write 0xAB00 data 128'h1122 on cold cache -> no mem traffic, ready in 2 cycles.
//  - Read 0xAB00 -> hit, cpu_req_dataout=32'h1122, no mem_req_valid.
//  - Read 0xBB00 (idx 0x3B0, clean miss), fill 128'h3344 after 2-cycle ready stall ->
//    one read: mem_req_addr=0xBB00, rw=0; dataout=32'h3344.
//  - Read 0xEB00 (idx 0x2B0 dirty, tag 2) -> write-back addr 0xAB00 data 128'h1122
//    rw=1, then fill addr 0xEB00; fill 128'h5566 -> dataout=32'h5566, line clean.
//  - Read 0x00000008 after fill 128'hDDDD_CCCC_BBBB_AAAA -> dataout=32'hCCCC.
//  - Assert rst during ALLOCATE -> mem_req_valid=0, cache_ready=1; re-read 0xAB00 misses.

Source files
------------

// File: rtl/dm_cache_controller_pkg.sv
// Shared types, geometry constants and address helpers for the direct-mapped cache.
package dm_cache_controller_pkg;

  localparam int ADDR_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int WORD_W   = 32;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  // Word 0 sits in the least-significant 32 bits of the block.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] block,
                                                 input logic [ADDR_W-1:0]  addr);
    logic [1:0] word_idx;
    word_idx = addr[3:2];
    return block[{word_idx, 5'b0} +: WORD_W];
  endfunction

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                   input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// CPU-side and memory-side buses of the cache controller.
// slave: the controller; master: the CPU/memory environment driving it.
interface dm_cache_controller_if;
  import dm_cache_controller_pkg::*;

  logic [ADDR_W-1:0]  cpu_req_addr;
  logic [BLOCK_W-1:0] cpu_req_datain;
  logic [WORD_W-1:0]  cpu_req_dataout;
  logic               cpu_req_rw;
  logic               cpu_req_valid;
  logic               cache_ready;

  logic [ADDR_W-1:0]  mem_req_addr;
  logic [BLOCK_W-1:0] mem_req_datain;
  logic [BLOCK_W-1:0] mem_req_dataout;
  logic               mem_req_rw;
  logic               mem_req_valid;
  logic               mem_req_ready;

  modport slave (
    input  cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
    output cpu_req_dataout, cache_ready,
    input  mem_req_datain, mem_req_ready,
    output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid
  );

  modport master (
    output cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
    input  cpu_req_dataout, cache_ready,
    output mem_req_datain, mem_req_ready,
    input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid
  );

endinterface

// File: rtl/dm_cache_controller_array.sv
// Line storage: data, tag, valid and dirty per line; one async read port, one write port.
// Valid/dirty are flops so reset can invalidate every line in a single cycle.
module dm_cache_array
  import dm_cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [BLOCK_W-1:0] rd_block,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [BLOCK_W-1:0] wr_block,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty
);

  logic [BLOCK_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]   valid_bits;
  logic [LINES-1:0]   dirty_bits;

  // Data and tag payload; no reset needed since valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_block;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  // Line status bits, cleared synchronously on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= wr_valid;
      dirty_bits[wr_index] <= wr_dirty;
    end
  end

  assign rd_block = data_mem[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller.
//
//   state      | meaning
//   IDLE       | cache_ready=1, waiting for a CPU request
//   COMPARE    | tag lookup on the registered request; hit, install or start a miss
//   WRITE_BACK | dirty victim block being written to memory
//   ALLOCATE   | fill of the requested block from memory (reads only)
module dm_cache_controller
  import dm_cache_controller_pkg::*;
(
  input logic              clk,
  input logic              rst,
  dm_cache_controller_if.slave bus
);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  req_addr;
  logic               req_rw;
  logic [BLOCK_W-1:0] req_data;
  logic [WORD_W-1:0]  rd_word;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [BLOCK_W-1:0] line_block;
  logic [TAG_W-1:0]   line_tag;
  logic               line_valid, line_dirty, hit;

  logic               load_req, load_word;
  logic               wr_en, wr_dirty;
  logic [BLOCK_W-1:0] wr_block;
  logic [TAG_W-1:0]   wr_tag;

  logic               mem_valid, mem_rw;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_dout;

  assign req_tag   = addr_tag(req_addr);
  assign req_index = addr_index(req_addr);
  assign hit       = line_valid && (line_tag == req_tag);

  dm_cache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_block (line_block),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .wr_en    (wr_en),
    .wr_index (req_index),
    .wr_block (wr_block),
    .wr_tag   (wr_tag),
    .wr_valid (1'b1),
    .wr_dirty (wr_dirty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture and CPU read-data register (holds until the next read hit).
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= '0;
      req_rw   <= 1'b0;
      req_data <= '0;
      rd_word  <= '0;
    end else begin
      if (load_req) begin
        req_addr <= bus.cpu_req_addr;
        req_rw   <= bus.cpu_req_rw;
        req_data <= bus.cpu_req_datain;
      end
      if (load_word) rd_word <= word_sel(line_block, req_addr);
    end
  end

  // Next-state, array write control and memory request outputs.
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    load_word  = 1'b0;
    wr_en      = 1'b0;
    wr_block   = req_data;
    wr_tag     = req_tag;
    wr_dirty   = 1'b1;
    mem_valid  = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_dout   = '0;
    case (state)
      IDLE: begin
        if (bus.cpu_req_valid) begin
          load_req   = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          if (req_rw) wr_en = 1'b1;
          else        load_word = 1'b1;
          state_next = IDLE;
        end else if (line_valid && line_dirty) begin
          state_next = WRITE_BACK;
        end else if (req_rw) begin
          wr_en      = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = block_addr(line_tag, req_index);
        mem_dout  = line_block;
        if (bus.mem_req_ready) begin
          wr_en = 1'b1;
          if (req_rw) begin
            state_next = IDLE;
          end else begin
            // Victim stays resident but clean until the fill replaces it.
            wr_block   = line_block;
            wr_tag     = line_tag;
            wr_dirty   = 1'b0;
            state_next = ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        mem_valid = 1'b1;
        mem_addr  = block_addr(req_tag, req_index);
        if (bus.mem_req_ready) begin
          wr_en      = 1'b1;
          wr_block   = bus.mem_req_datain;
          wr_dirty   = 1'b0;
          state_next = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cache_ready     = (state == IDLE);
  assign bus.cpu_req_dataout = rd_word;
  assign bus.mem_req_valid   = mem_valid;
  assign bus.mem_req_rw      = mem_rw;
  assign bus.mem_req_addr    = mem_addr;
  assign bus.mem_req_dataout = mem_dout;

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench for dm_cache_controller with a memory-transaction and read-data scoreboard.
module tb_dm_cache_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_cache_controller_if bus();

  dm_cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         rw;
    logic [127:0] wdata;
    logic [127:0] fill;
    int           stall;
  } mem_exp_t;

  mem_exp_t     mem_q[$];
  logic [31:0]  rd_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic exp_mem(input logic [31:0] addr, input logic rw, input logic [127:0] wdata,
                         input logic [127:0] fill, input int stall);
    mem_exp_t e;
    e.addr = addr; e.rw = rw; e.wdata = wdata; e.fill = fill; e.stall = stall;
    mem_q.push_back(e);
  endtask

  // Issue one CPU request, serve memory from the scoreboard, then check completion.
  // exp_word is the expected cpu_req_dataout afterwards (held value for writes).
  task automatic do_req(input string tag, input logic [31:0] addr, input logic rw,
                        input logic [127:0] data, input logic [31:0] exp_word, input int exp_lat);
    int cycles;
    int stall;
    mem_exp_t e;
    logic [31:0] want;
    rd_q.push_back(exp_word);
    bus.cpu_req_addr   = addr;
    bus.cpu_req_rw     = rw;
    bus.cpu_req_datain = data;
    bus.cpu_req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    cycles = 1;
    stall  = 0;
    while (!bus.cache_ready && cycles < 60) begin
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        if (mem_q.size() > 0 && stall < mem_q[0].stall) begin
          stall++;
        end else begin
          check({tag, "_mem_expected"}, mem_q.size() > 0, 1'b1);
          if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            check({tag, "_mem_addr"}, bus.mem_req_addr, e.addr);
            check({tag, "_mem_rw"}, bus.mem_req_rw, e.rw);
            if (e.rw) check({tag, "_mem_wdata"}, bus.mem_req_dataout, e.wdata);
            bus.mem_req_datain = e.fill;
            bus.mem_req_ready  = 1'b1;
            stall = 0;
          end
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.mem_req_ready = 1'b0;
    check({tag, "_done"}, bus.cache_ready, 1'b1);
    if (exp_lat > 0) check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_mem_drained"}, mem_q.size(), 0);
    want = rd_q.pop_front();
    check({tag, "_dataout"}, bus.cpu_req_dataout, want);
  endtask

  localparam logic [127:0] FILL_Q = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
  localparam logic [127:0] W1     = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
  localparam logic [127:0] W2     = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};

  initial begin
    int wait_cyc;
    bus.cpu_req_addr   = '0;
    bus.cpu_req_datain = '0;
    bus.cpu_req_rw     = 1'b0;
    bus.cpu_req_valid  = 1'b0;
    bus.mem_req_datain = '0;
    bus.mem_req_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cache_ready", bus.cache_ready, 1'b1);
    check("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_rw", bus.mem_req_rw, 1'b0);
    check("rst_mem_addr", bus.mem_req_addr, 32'h0);
    check("rst_mem_dataout", bus.mem_req_dataout, 128'h0);
    check("rst_cpu_dataout", bus.cpu_req_dataout, 32'h0);

    // Cold write miss installs without memory traffic.
    do_req("wr_cold", 32'hAB00, 1'b1, 128'h1122, 32'h0, 2);
    do_req("rd_hit", 32'hAB00, 1'b0, 128'h0, 32'h1122, 2);
    // Clean miss with a two-cycle memory stall.
    exp_mem(32'hBB00, 1'b0, 128'h0, 128'h3344, 2);
    do_req("rd_clean_miss", 32'hBB00, 1'b0, 128'h0, 32'h3344, -1);
    // Dirty victim: write-back then fill.
    exp_mem(32'hAB00, 1'b1, 128'h1122, 128'h0, 0);
    exp_mem(32'hEB00, 1'b0, 128'h0, 128'h5566, 1);
    do_req("rd_dirty_miss", 32'hEB00, 1'b0, 128'h0, 32'h5566, -1);
    do_req("rd_hit_word1", 32'hEB04, 1'b0, 128'h0, 32'h0, 2);
    // Filled line is clean: evicting it needs no write-back.
    exp_mem(32'h2B00, 1'b0, 128'h0, 128'h99, 0);
    do_req("rd_evict_clean", 32'h2B00, 1'b0, 128'h0, 32'h99, -1);
    exp_mem(32'h0, 1'b0, 128'h0, FILL_Q, 0);
    do_req("rd_word2", 32'h8, 1'b0, 128'h0, 32'hCCCC, -1);
    // Write hit keeps read data; then dirty write miss writes back, installs, no fill.
    do_req("wr_hit", 32'h8, 1'b1, W1, 32'hCCCC, 2);
    do_req("rd_after_wr", 32'h4, 1'b0, 128'h0, 32'h2222_0002, 2);
    exp_mem(32'h0, 1'b1, W1, 128'h0, 0);
    do_req("wr_dirty_miss", 32'h4008, 1'b1, W2, 32'h2222_0002, -1);
    do_req("rd_after_wr_miss", 32'h4008, 1'b0, 128'h0, 32'hCAFE_0003, 2);

    // Reset in the middle of a fill.
    bus.cpu_req_addr  = 32'h1000;
    bus.cpu_req_rw    = 1'b0;
    bus.cpu_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    wait_cyc = 0;
    while (!bus.mem_req_valid && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("alloc_valid", bus.mem_req_valid, 1'b1);
    check("alloc_rw", bus.mem_req_rw, 1'b0);
    check("alloc_addr", bus.mem_req_addr, 32'h1000);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_mem_valid", bus.mem_req_valid, 1'b0);
    check("midrst_cache_ready", bus.cache_ready, 1'b1);
    check("midrst_cpu_dataout", bus.cpu_req_dataout, 32'h0);
    rst = 1'b0;
    exp_mem(32'hAB00, 1'b0, 128'h0, 128'h7788, 0);
    do_req("reread_miss", 32'hAB00, 1'b0, 128'h0, 32'h7788, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
